// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM.
// Steps each instruction through fetch, decode, execute, memory and write-back
// states. All outputs are decoded from the state register. The exceptions are
// the FETCH write enables, which depend on mem_ready. Three states wait on
// memory: FETCH, MEM_RD and MEM_WR. A watchdog limits each of those waits to
// MEM_TIMEOUT cycles. When it expires, the FSM pulses mem_err and returns to
// FETCH.
//
// Optional feature macro: MC_ADDI_EN
//   defined   -> opcode 001000 (addi) runs DECODE -> MEM_ADDR -> ADDI_WB
//   undefined -> opcode 001000 is illegal and ADDI_WB is unreachable
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   opcode[5:0]        instr[31:26] from the instruction register
//   mem_ready          memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_source[1:0]    datapath controls
//   illegal_op         one-cycle pulse on an undecodable opcode in DECODE
//   mem_err            one-cycle pulse on watchdog expiry
//   state_dbg[3:0]     current state encoding
module mc_main_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             mem_wait;

  // State and watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d       = state_q;
    wd_d          = '0;
    mem_wait      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_wait  = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = S_MEM_ADDR;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
`ifdef MC_ADDI_EN
        else if (opcode == OP_ADDI) state_d = S_ADDI_WB;
`endif
        else                      state_d = S_FETCH;
      end

      S_MEM_RD: begin
        mem_wait = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_wait  = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end

      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    // Watchdog: counts stalled cycles. A ready on the expiry cycle still
    // completes the access because this branch only runs when mem_ready is low.
    if (mem_wait && !mem_ready) begin
      if (wd_q == WD_LAST) begin
        mem_err = 1'b1;
        state_d = S_FETCH;
      end else begin
        wd_d = wd_q + CNT_W'(1);
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl. The stimulus plan is built up front.
// For each planned cycle it holds the instruction's memory behaviour and the
// expected outputs derived from the instruction flow. A driver plays the plan
// and queues the expectations. A monitor compares on each falling edge.
module tb_mc_main_ctrl;

  localparam int T = 4;  // MEM_TIMEOUT used for this build

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                 S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC_R = 7,
                 S_R_WB = 8, S_BRANCH = 9, S_JUMP = 10, S_ADDI_WB = 11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state_dbg;
  } ov_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    ov_t        exp;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, mem_err;
  logic [3:0] state_dbg;

  stim_t stim_q[$];
  ov_t   sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err),
    .state_dbg(state_dbg)
  );

  // Expected control word for a given phase of an instruction
  function automatic ov_t mk(input int st, input logic rdy, input logic err, input logic ill);
    ov_t o;
    o = '0;
    o.state_dbg = 4'(st);
    case (st)
      S_FETCH:    begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      S_DECODE:   o.alu_src_b = 2'b11;
      S_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      S_MEM_RD:   begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      S_MEM_WB:   begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      S_EXEC_R:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      S_R_WB:     begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      S_BRANCH:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
      S_JUMP:     begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
      S_ADDI_WB:  o.reg_write = 1'b1;
      default:    ;
    endcase
    o.mem_err    = err;
    o.illegal_op = ill;
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    bit l;
    l = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h02);
`ifdef MC_ADDI_EN
    l = l || (op == 6'h08);
`endif
    return l;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic emit(input logic rst, input logic [5:0] op, input logic rdy, input ov_t e);
    stim_t s;
    s.rst = rst; s.op = op; s.rdy = rdy; s.exp = e;
    stim_q.push_back(s);
  endtask

  // Memory-waiting phase: w stalled cycles before ready. If w reaches the
  // timeout, the watchdog fires on stalled cycle T and the access aborts.
  task automatic access(input int st, input logic [5:0] op, input int w, output bit ok);
    if (w < T) begin
      for (int i = 0; i < w; i++) emit(1'b0, op, 1'b0, mk(st, 1'b0, 1'b0, 1'b0));
      emit(1'b0, op, 1'b1, mk(st, 1'b1, 1'b0, 1'b0));
      ok = 1'b1;
    end else begin
      for (int i = 0; i < T - 1; i++) emit(1'b0, op, 1'b0, mk(st, 1'b0, 1'b0, 1'b0));
      emit(1'b0, op, 1'b0, mk(st, 1'b0, 1'b1, 1'b0));
      ok = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit ok;
    access(S_FETCH, op, fw, ok);
    while (!ok) access(S_FETCH, op, 0, ok);
    emit(1'b0, op, rnd_bit(), mk(S_DECODE, 1'b0, 1'b0, !is_legal(op)));
    if (!is_legal(op)) return;
    case (op)
      6'h00: begin
        emit(1'b0, op, rnd_bit(), mk(S_EXEC_R, 1'b0, 1'b0, 1'b0));
        emit(1'b0, op, rnd_bit(), mk(S_R_WB, 1'b0, 1'b0, 1'b0));
      end
      6'h04: emit(1'b0, op, rnd_bit(), mk(S_BRANCH, 1'b0, 1'b0, 1'b0));
      6'h02: emit(1'b0, op, rnd_bit(), mk(S_JUMP, 1'b0, 1'b0, 1'b0));
      6'h23: begin
        emit(1'b0, op, rnd_bit(), mk(S_MEM_ADDR, 1'b0, 1'b0, 1'b0));
        access(S_MEM_RD, op, mw, ok);
        if (ok) emit(1'b0, op, rnd_bit(), mk(S_MEM_WB, 1'b0, 1'b0, 1'b0));
      end
      6'h2b: begin
        emit(1'b0, op, rnd_bit(), mk(S_MEM_ADDR, 1'b0, 1'b0, 1'b0));
        access(S_MEM_WR, op, mw, ok);
      end
      default: begin  // addi
        emit(1'b0, op, rnd_bit(), mk(S_MEM_ADDR, 1'b0, 1'b0, 1'b0));
        emit(1'b0, op, rnd_bit(), mk(S_ADDI_WB, 1'b0, 1'b0, 1'b0));
      end
    endcase
  endtask

  task automatic build_plan();
    logic [5:0] pool [7];
    bit ok;
    pool[0] = 6'h00; pool[1] = 6'h23; pool[2] = 6'h2b; pool[3] = 6'h04;
    pool[4] = 6'h02; pool[5] = 6'h08; pool[6] = 6'h3f;
    // second reset cycle, then release: still IDLE for one cycle
    emit(1'b1, 6'h00, 1'b1, mk(S_IDLE, 1'b0, 1'b0, 1'b0));
    emit(1'b0, 6'h00, 1'b1, mk(S_IDLE, 1'b0, 1'b0, 1'b0));
    run_instr(6'h23, 0, 0);        // lw
    run_instr(6'h00, 0, 0);        // R-type
    run_instr(6'h04, 0, 0);        // beq
    run_instr(6'h02, 0, 0);        // j
    run_instr(6'h2b, 0, 3);        // sw, 3 stall cycles
    run_instr(6'h23, 0, T + 1);    // lw, memory never ready
    run_instr(6'h3f, 0, 0);        // illegal
    run_instr(6'h08, 0, 0);        // addi / illegal depending on build
    run_instr(6'h00, T, 0);        // fetch timeout then retry
    run_instr(6'h04, T - 1, 0);    // ready exactly on expiry cycle in FETCH
    run_instr(6'h23, 0, T - 1);    // ready exactly on expiry cycle in MEM_RD
    run_instr(6'h2b, 0, T);        // sw timeout
    // reset in the middle of an lw
    access(S_FETCH, 6'h23, 0, ok);
    emit(1'b0, 6'h23, rnd_bit(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
    emit(1'b1, 6'h23, rnd_bit(), mk(S_MEM_ADDR, 1'b0, 1'b0, 1'b0));
    emit(1'b0, 6'h23, rnd_bit(), mk(S_IDLE, 1'b0, 1'b0, 1'b0));
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int         k;
      k  = int'($urandom_range(0, 7));
      op = (k == 7) ? 6'($urandom_range(0, 63)) : pool[k];
      run_instr(op, int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)));
    end
  endtask

  // Driver: applies one planned cycle after each rising edge
  initial begin
    stim_t s;
    reset     = 1'b1;
    opcode    = 6'h00;
    mem_ready = 1'b1;
    build_plan();
    @(posedge clk);
    #1;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset     = s.rst;
      opcode    = s.op;
      mem_ready = s.rdy;
      sb.push_back(s.exp);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: compares the control word mid-cycle
  always @(negedge clk) begin
    ov_t act, e;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, mem_err, state_dbg};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outs t=%0t state got %0d want %0d: word got %h want %h",
                 $time, act.state_dbg, e.state_dbg, act, e);
      end
    end
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle MIPS main control FSM; the stage directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode.
- Produces datapath enables plus the 2-bit ALU op consumed by the ALU control decoder.
- Adds a memory-ready handshake with a watchdog timeout so the core tolerates multi-cycle memory.

Parameters:
- MEM_TIMEOUT, 15, max cycles spent waiting for mem_ready in one memory state before abort (1..255).
- CNT_W, 8, width of watchdog counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut does
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 use funct (to ALU control decoder)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse: undecodable opcode seen in DECODE
- mem_err  out  1  one-cycle pulse: watchdog expired
- state_dbg  out  4  current state encoding, for the simulator trace

Behaviour:
- Reset (sync): state = IDLE, watchdog = 0, all outputs 0. IDLE -> FETCH on the next clock with reset low.
- Outputs are decoded from the state register (Moore). Exceptions: ir_write and pc_write in FETCH are gated by mem_ready.
- State encodings 0-11 in this order: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, ADDI_WB.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> MEM_ADDR (when the ADDI feature is enabled; path defined under Optional Feature)
  - anything else -> illegal_op=1 for that cycle, then FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEM_RD, sw -> MEM_WR, addi -> ADDI_WB. opcode is held stable by the IR.
- MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1; wait for mem_ready, then FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- Instruction latency excluding memory waits: lw 5, sw 4, R 4, beq 3, j 3, addi 4 cycles.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - Counter clears on entering the state and increments each cycle mem_ready=0.
  - If the counter equals MEM_TIMEOUT-1 while mem_ready=0: mem_err=1 for one cycle, next state FETCH, counter cleared.
  - mem_ready on the same cycle as expiry wins; the access completes normally.
- No write-enable output (pc_write, reg_write, mem_write, ir_write) is ever asserted in IDLE.
- Reset asserted mid-instruction: state = IDLE on that clock and all outputs 0 in the following cycle.

Optional Feature:
- Macro MC_ADDI_EN.
- Defined: opcode 001000 decodes as addi (DECODE -> MEM_ADDR -> ADDI_WB).
- Undefined: 001000 is illegal (illegal_op pulse, return to FETCH) and ADDI_WB is unreachable.

Test Plan:
- Reset held 2 cycles, then released, mem_ready=1 -> all outputs 0 during reset; state_dbg 0 then 1; FETCH asserts mem_read, ir_write, pc_write.
- lw (100011), mem_ready=1 -> state sequence 1,2,3,4,5,1; reg_write and mem_to_reg high only in state 5.
- R-type (000000) -> alu_op=10 in EXEC_R; R_WB has reg_dst=1, reg_write=1; 4 cycles total.
- beq (000100) -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=01; j (000010) -> JUMP has pc_write=1, pc_source=10.
- sw with mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH. mem_ready never high with MEM_TIMEOUT=4 -> mem_err pulses on the 4th wait cycle, then FETCH.
- opcode 111111 -> illegal_op one-cycle pulse in DECODE, then FETCH. opcode 001000 -> addi path with MC_ADDI_EN defined; illegal_op pulse without it.
